// File: rtl/pm1_pkg.sv
// Shared pm1 types: port widths, captured-vector type and the {ts, vec} entry layout.
package pm1_pkg;

    localparam int PM1_NIN      = 16;
    localparam int PM1_NOUT     = 13;
    localparam int PM1_TS_W_DEF = 16;

    typedef logic [PM1_NOUT-1:0] pm1_out_t;

    // Default-width entry layout; the vector sits in the LSBs.
    typedef struct packed {
        logic [PM1_TS_W_DEF-1:0] ts;
        pm1_out_t                vec;
    } cap_entry_t;

    // Entry width for an arbitrary timestamp width.
    function automatic int cap_entry_w(input int ts_w);
        return ts_w + PM1_NOUT;
    endfunction

endpackage

// File: rtl/pm1_event_capture_if.sv
// Sample input and FIFO drain port of the pm1 event-capture stage.
interface pm1_event_capture_if #(
    parameter int TS_W = 16
);
    import pm1_pkg::*;

    pm1_out_t                   in_vec;
    logic                       in_valid;
    logic                       out_ready;
    logic                       out_valid;
    logic [TS_W+PM1_NOUT-1:0]   out_data;

    modport master (
        output in_vec, in_valid, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/pm1_cap_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO succeeds only when a pop shares the edge.
module pm1_cap_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 29,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] head
);

    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push_s, do_pop_s;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == FULL_LVL);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/pm1_event_capture.sv
// Time-stamped capture of pm1 output vectors into a drainable FIFO.
// Define PM1_CAP_FILTER_EN to queue only changed vectors; otherwise every valid sample is queued.
module pm1_event_capture
    import pm1_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int TS_W  = 16,
    parameter  int DC_W  = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pm1_event_capture_if.slave     bus,
    input  logic                   clr_ovf,
    output logic                   overflow,
    output logic [DC_W-1:0]        drop_cnt,
    output logic [LW-1:0]          level
);

    localparam int              EW      = cap_entry_w(TS_W);
    localparam logic [TS_W-1:0] TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0] DC_ONE  = {{(DC_W-1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0] DC_MAX  = {DC_W{1'b1}};

    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] ts1_q, ts1_d;
    pm1_out_t        vec1_q, vec1_d;
    logic            v1_q, v1_d;
    logic            ovf_q, ovf_d;
    logic [DC_W-1:0] drop_q, drop_d;

    logic            push_s, pop_s, drop_s;
    logic            full_s, empty_s;
    logic [EW-1:0]   head_s;
    logic [LW-1:0]   level_s;

    // Free-running timestamp and S1 sample capture.
    always_comb begin
        ts_d = ts_q + TS_ONE;
        v1_d = bus.in_valid;
        if (bus.in_valid) begin
            vec1_d = bus.in_vec;
            ts1_d  = ts_q;
        end else begin
            vec1_d = vec1_q;
            ts1_d  = ts1_q;
        end
    end

`ifdef PM1_CAP_FILTER_EN
    pm1_out_t last_vec_q, last_vec_d;
    logic     first_seen_q, first_seen_d;

    // Change detection; last_vec follows every event, even one that is later dropped.
    always_comb begin
        push_s       = 1'b0;
        last_vec_d   = last_vec_q;
        first_seen_d = first_seen_q;
        if (v1_q && (!first_seen_q || (vec1_q != last_vec_q))) begin
            push_s       = 1'b1;
            last_vec_d   = vec1_q;
            first_seen_d = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Change-detector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vec_q   <= '0;
            first_seen_q <= 1'b0;
        end else begin
            last_vec_q   <= last_vec_d;
            first_seen_q <= first_seen_d;
        end
    end
`else
    assign push_s = v1_q;
`endif

    // Drop accounting; a drop in the same cycle as a clear leaves a count of one.
    always_comb begin
        pop_s  = !empty_s && bus.out_ready;
        drop_s = push_s && full_s && !pop_s;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop_s) begin
            ovf_d = 1'b1;
            if (clr_ovf) begin
                drop_d = DC_ONE;
            end else if (drop_q != DC_MAX) begin
                drop_d = drop_q + DC_ONE;
            end else begin
                drop_d = drop_q;
            end
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // Timestamp, S1 and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            ts1_q  <= '0;
            vec1_q <= '0;
            v1_q   <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            ts1_q  <= ts1_d;
            vec1_q <= vec1_d;
            v1_q   <= v1_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    pm1_cap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({ts1_q, vec1_q}),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s),
        .head      (head_s)
    );

    assign bus.out_valid = !empty_s;
    assign bus.out_data  = head_s;
    assign level         = level_s;
    assign overflow      = ovf_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_pm1_event_capture.sv
// Scoreboard bench for pm1_event_capture: a queue-level reference model feeds expected entries to a drain monitor.
module tb_pm1_event_capture;
    import pm1_pkg::*;

    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int DC_W  = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int DMAX  = (1 << DC_W) - 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr_ovf;
    logic            overflow;
    logic [DC_W-1:0] drop_cnt;
    logic [LW-1:0]   level;

    pm1_event_capture_if #(.TS_W(TS_W)) bus ();

    pm1_event_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .DC_W(DC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected queue contents, occupancy, flags, timestamp, pending sample.
    logic [TS_W+PM1_NOUT-1:0] exp_q[$];
    logic [TS_W-1:0]          m_ts;
    int                       m_level;
    logic                     m_ovf;
    int                       m_drop;
    logic                     p_valid;
    pm1_out_t                 p_vec;
    logic [TS_W-1:0]          p_ts;
    logic                     m_seen;
    pm1_out_t                 m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, ev;
        pop = (m_level > 0) && bus.out_ready;
        ev  = p_valid;
`ifdef PM1_CAP_FILTER_EN
        ev = p_valid && (!m_seen || (p_vec != m_last));
        if (ev) begin
            m_seen = 1'b1;
            m_last = p_vec;
        end
`endif
        if (ev && (m_level == DEPTH) && !pop) begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 1 : ((m_drop < DMAX) ? m_drop + 1 : DMAX);
        end else begin
            if (clr_ovf) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (ev) begin
                exp_q.push_back({p_ts, p_vec});
                m_level++;
            end
        end
        if (pop) m_level--;
        p_valid = bus.in_valid;
        p_vec   = bus.in_vec;
        p_ts    = m_ts;
        m_ts    = m_ts + 16'd1;
    endtask

    task automatic cycle(input bit v, input logic [12:0] vec, input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.in_vec    = vec;
        bus.out_ready = rdy;
        clr_ovf       = clr;
        @(posedge clk);
        model_edge();
        #1;
        chk("level", 32'(level), 32'(m_level));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_vec    = 13'h0000;
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        rst_n         = 1'b0;
        exp_q.delete();
        m_ts = 16'h0000; m_level = 0; m_ovf = 1'b0; m_drop = 0;
        p_valid = 1'b0; p_vec = 13'h0000; p_ts = 16'h0000;
        m_seen = 1'b0; m_last = 13'h0000;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drain monitor: out_valid must track the expected queue; every pop is compared against its head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL pop_unexpected actual=%0h required=none @%0t", bus.out_data, $time);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [12:0] rv;
        bus.in_valid = 1'b0; bus.in_vec = 13'h0000; bus.out_ready = 1'b0; clr_ovf = 1'b0;
        #2;
        do_reset();

        // First sample at ts=5 appears two cycles later.
        while (m_ts != 16'd5) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        cycle(1'b1, 13'h0003, 1'b1, 1'b0);
        chk("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        chk("lat_t2_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_t2_data", 32'(bus.out_data), 32'({16'd5, 13'h0003}));
        repeat (2) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        chk("lat_level0", 32'(level), 32'd0);

        // Held vector, then a change.
        repeat (10) cycle(1'b1, 13'h1ABC, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 13'h0000, 1'b0, 1'b0);
`ifdef PM1_CAP_FILTER_EN
        chk("hold_level", 32'(level), 32'd1);
`else
        chk("hold_level", 32'(level), 32'd4);
`endif
        cycle(1'b1, 13'h0ABC, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 13'h0000, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        cycle(1'b0, 13'h0000, 1'b1, 1'b1);

        // Six distinct vectors into a stalled FIFO.
        for (int i = 0; i < 6; i++) cycle(1'b1, 13'(13'h0100 + i), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 13'h0000, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_cnt), 32'd2);
        repeat (6) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        cycle(1'b0, 13'h0000, 1'b1, 1'b1);

        // Full FIFO with a push and a pop on the same edge.
        for (int i = 0; i < 5; i++) cycle(1'b1, 13'(13'h0200 + i), 1'b0, 1'b0);
        cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        chk("pp_full_level", 32'(level), 32'd4);
        chk("pp_full_drops", 32'(drop_cnt), 32'd0);
        repeat (6) cycle(1'b0, 13'h0000, 1'b1, 1'b0);

        // Randomized traffic with bursts of stall and occasional clears.
        rv = 13'h0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rv = 13'($urandom);
            cycle(1'($urandom_range(0, 1)), rv, ((i / 40) % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b1,
                  ($urandom_range(0, 31) == 0));
        end
        repeat (6) cycle(1'b0, 13'h0000, 1'b1, 1'b0);

        // Reset with three queued entries, then a zero vector must still be captured.
        for (int i = 0; i < 3; i++) cycle(1'b1, 13'(13'h0300 + i), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 13'h0000, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        do_reset();
        cycle(1'b1, 13'h0000, 1'b0, 1'b0);
        cycle(1'b0, 13'h0000, 1'b0, 1'b0);
        chk("post_rst_level", 32'(level), 32'd1);
        repeat (3) cycle(1'b0, 13'h0000, 1'b1, 1'b0);

        // Timestamp wrap.
        while (m_ts != 16'hFFFF) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
        cycle(1'b1, 13'h0155, 1'b0, 1'b0);
        cycle(1'b1, 13'h0AAA, 1'b0, 1'b0);
        cycle(1'b0, 13'h0000, 1'b0, 1'b0);
        chk("wrap_head", 32'(bus.out_data), 32'({16'hFFFF, 13'h0155}));
        repeat (4) cycle(1'b0, 13'h0000, 1'b1, 1'b0);

        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
